// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: op and FSM encodings plus the fixed TMS walks around each scan.
package jtag_master_pkg;
  typedef enum logic [1:0] {OP_RESET, OP_SHIFT_IR, OP_SHIFT_DR, OP_IDLE} op_e;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_e;
  // TMS patterns are stored LSB = first slot
  localparam logic [5:0] PRE_RESET = 6'b011111;
  localparam logic [5:0] PRE_IR = 6'b000011;
  localparam logic [5:0] PRE_DR = 6'b000001;
  localparam logic [5:0] POST_PAT = 6'b000001;
  function automatic logic is_scan(op_e op);
    return op == OP_SHIFT_IR || op == OP_SHIFT_DR;
  endfunction
  function automatic logic [5:0] pre_pat(op_e op);
    return op == OP_RESET ? PRE_RESET : op == OP_SHIFT_IR ? PRE_IR : op == OP_SHIFT_DR ? PRE_DR : 6'b0;
  endfunction
  function automatic logic [2:0] pre_len(op_e op);
    return op == OP_RESET ? 3'd6 : op == OP_SHIFT_IR ? 3'd4 : op == OP_SHIFT_DR ? 3'd3 : 3'd0;
  endfunction
  function automatic logic [2:0] post_len(op_e op);
    return is_scan(op) ? 3'd2 : 3'd0;
  endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into TCK slots and flags slot boundaries and rising edges.
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic trst,
  input  logic start,
  input  logic run,
  output logic tck,
  output logic slot_start,
  output logic rise
);
  localparam int PW = $clog2(2 * TCK_DIV);
  logic [PW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == PW'(2 * TCK_DIV - 1);
  assign rise = run && cnt == PW'(TCK_DIV - 1);
  assign slot_start = start || (run && wrap);
  always_ff @(posedge clk or negedge trst)
    if (!trst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= run && !wrap ? cnt + PW'(1) : '0;
      tck <= run && (rise || (tck && !wrap));
    end
endmodule

// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG shift engine driving TCK/TMS/TDI and capturing TDO.
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int TCK_DIV = 2,
  parameter int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);
  state_e state, state_d, after_pre, after_shift;
  op_e op_q, op_c;
  logic [LW-1:0] len_q, len_c, idx, idx_d;
  logic [2:0] pidx, pidx_d;
  logic [5:0] pre_v;
  logic [MAX_LEN-1:0] sr, cap;
  logic synced, err_q, accept, bad, scan, run, slot_start, rise, tms_d, tdi_d;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk(clk), .trst(trst), .start(accept), .run(run),
    .tck(tck), .slot_start(slot_start), .rise(rise)
  );

  assign run = state inside {S_PRE, S_SHIFT, S_POST};
  assign rsp_valid = state == S_RESP;
  assign cmd_ready = state == S_IDLE && !rsp_valid;
  assign rsp_data = cap;
  assign rsp_err = err_q;

  // op/len come straight from the command port while idle so the first slot can be set up at acceptance
  always_comb begin
    op_c = state == S_IDLE ? op_e'(cmd_op) : op_q;
    len_c = state == S_IDLE ? cmd_len : len_q;
    scan = is_scan(op_c);
    pre_v = pre_pat(op_c);
    accept = cmd_valid && cmd_ready;
    bad = op_c != OP_RESET && (!synced || len_c == '0 || (scan && len_c > LW'(MAX_LEN)));
    after_shift = post_len(op_c) != 3'd0 ? S_POST : S_RESP;
    after_pre = op_c != OP_RESET && len_c != '0 ? S_SHIFT : after_shift;
    state_d = state;
    pidx_d = pidx;
    idx_d = idx;
    case (state)
      S_IDLE: if (accept) begin
        state_d = bad ? S_RESP : pre_len(op_c) != 3'd0 ? S_PRE : after_pre;
        pidx_d = '0;
        idx_d = '0;
      end
      S_PRE: if (slot_start) begin
        pidx_d = pidx + 3'd1 == pre_len(op_c) ? 3'd0 : pidx + 3'd1;
        state_d = pidx + 3'd1 == pre_len(op_c) ? after_pre : S_PRE;
      end
      S_SHIFT: if (slot_start) begin
        idx_d = idx + LW'(1);
        state_d = idx_d == len_c ? after_shift : S_SHIFT;
      end
      S_POST: if (slot_start) begin
        pidx_d = pidx + 3'd1;
        state_d = pidx_d == post_len(op_c) ? S_RESP : S_POST;
      end
      S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
    tms_d = state_d == S_PRE ? pre_v[pidx_d] : state_d == S_POST ? POST_PAT[pidx_d] :
            state_d == S_SHIFT && scan && idx_d == len_c - LW'(1);
    tdi_d = state_d == S_SHIFT && scan && sr[0];
  end

  always_ff @(posedge clk or negedge trst)
    if (!trst) begin
      state <= S_IDLE;
      op_q <= OP_RESET;
      len_q <= '0;
      idx <= '0;
      pidx <= '0;
      sr <= '0;
      cap <= '0;
      synced <= 1'b0;
      err_q <= 1'b0;
      tms <= 1'b1;
      tdi <= 1'b0;
    end else begin
      state <= state_d;
      pidx <= pidx_d;
      idx <= idx_d;
      if (accept) begin
        op_q <= op_c;
        len_q <= cmd_len;
        sr <= cmd_data;
        cap <= '0;
        err_q <= bad;
      end else if (slot_start && state_d == S_SHIFT)
        sr <= sr >> 1;
      if (rise && state == S_SHIFT && scan)
        cap <= cap | (MAX_LEN'(tdo) << idx);
      if (state == S_PRE && state_d == S_RESP && op_q == OP_RESET)
        synced <= 1'b1;
      // tms/tdi only move at slot boundaries, so they are stable across each TCK rise
      if (slot_start && state_d inside {S_PRE, S_SHIFT, S_POST}) begin
        tms <= tms_d;
        tdi <= tdi_d;
      end
    end
endmodule
